// File: rtl/prim_freepdk45_pkg.sv
// prim_freepdk45_pkg: shared macro geometry, init FSM states and config type for FreePDK45 RAM primitives
package prim_freepdk45_pkg;
  localparam int MacroWidth = 32;
  localparam int MacroDepth = 2048;
  localparam int MacroAw = 11;
  typedef enum logic {INIT, READY} init_state_e;
  typedef struct packed {
    logic       ram_cfg_en;
    logic [3:0] ram_cfg;
  } ram_1p_cfg_t;
endpackage

// File: rtl/prim_freepdk45_ram_1p_init.sv
// prim_freepdk45_ram_1p_init: INIT/READY sequencer sweeping every macro word once after reset
module prim_freepdk45_ram_1p_init
  import prim_freepdk45_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               init_busy,
  output logic [MacroAw-1:0] init_addr,
  output logic               init_we
);
  init_state_e state_q, state_d;
  logic [MacroAw-1:0] cnt_q, cnt_d;
  // state and fill counter; reset always restarts the sweep at word 0
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // advance one word per cycle, leave INIT after the last word
  always_comb begin
    init_busy = state_q == INIT;
    init_we = init_busy;
    init_addr = cnt_q;
    cnt_d = init_busy ? cnt_q + 1'b1 : '0;
    state_d = (init_busy && &cnt_q) ? READY : state_q;
  end
endmodule

// File: rtl/sram_32x2048_1rw.sv
// sram_32x2048_1rw: behavioural 32x2048 single-port macro, per-bit write mask, registered read, no reset
module sram_32x2048_1rw (
  input  logic        clk,
  input  logic        ce,
  input  logic        we,
  input  logic [10:0] addr,
  input  logic [31:0] wmask,
  input  logic [31:0] din,
  output logic [31:0] dout
);
  logic [31:0] mem [2048];
  // masked write or registered read; dout holds its value across writes
  always_ff @(posedge clk) begin
    if (ce && we) mem[addr] <= (mem[addr] & ~wmask) | (din & wmask);
    if (ce && !we) dout <= mem[addr];
  end
endmodule

// File: rtl/prim_freepdk45_ram_1p_tiled.sv
// prim_freepdk45_ram_1p_tiled: tiled 1-port RAM with zero-fill, req/gnt and rvalid; PRIM_RAM_1P_OUTREG_EN adds an output register
module prim_freepdk45_ram_1p_tiled
  import prim_freepdk45_pkg::*;
#(
  parameter int Width = 64,
  parameter int Depth = 4096,
  parameter int DataBitsPerMask = 1,
  parameter MemInitFile = "",
  localparam int Aw = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              write_i,
  input  logic [Aw-1:0]     addr_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic [Width-1:0]  wmask_i,
  output logic              rvalid_o,
  output logic [Width-1:0]  rdata_o,
  output logic              init_busy_o,
  input  ram_1p_cfg_t       cfg_i
);
  localparam int NumCols = Width / MacroWidth;
  localparam int NumRows = Depth / MacroDepth;
  localparam int RowW = Aw > MacroAw ? Aw - MacroAw : 1;
  localparam int NumSlots = 2 ** RowW;

  if (Width % MacroWidth != 0 || Depth % MacroDepth != 0 || DataBitsPerMask != 1) begin : g_bad_cfg
    $fatal(1, "prim_freepdk45_ram_1p_tiled: unsupported Width/Depth/DataBitsPerMask");
  end

  logic init_busy, init_we;
  logic [MacroAw-1:0] init_addr;
  logic unused_cfg;
  logic gnt, rd_pend;
  logic [RowW-1:0] row, rd_row;
  logic [MacroAw-1:0] m_addr;
  logic m_we;
  logic [Width-1:0] m_wdata, m_wmask, rd_data;
  logic [Width-1:0] dout [NumSlots];

  prim_freepdk45_ram_1p_init u_init (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .init_busy (init_busy),
    .init_addr (init_addr),
    .init_we   (init_we)
  );

  assign unused_cfg = ^cfg_i;
  assign init_busy_o = init_busy;
  assign gnt = req_i & ~init_busy;
  assign gnt_o = gnt;
  assign row = RowW'(addr_i >> MacroAw);
  assign m_addr = init_busy ? init_addr : addr_i[MacroAw-1:0];
  assign m_we = init_busy ? init_we : write_i;
  assign m_wdata = init_busy ? '0 : wdata_i;
  assign m_wmask = init_busy ? '1 : wmask_i;

  // rows past Depth have no macros and read as zero, so out-of-range writes vanish
  for (genvar r = 0; r < NumSlots; r++) begin : g_row
    if (r < NumRows) begin : g_mac
      logic ce;
      assign ce = init_busy | (gnt & (row == RowW'(r)));
      for (genvar c = 0; c < NumCols; c++) begin : g_col
        sram_32x2048_1rw u_sram (
          .clk   (clk_i),
          .ce    (ce),
          .we    (m_we),
          .addr  (m_addr),
          .wmask (m_wmask[c*MacroWidth +: MacroWidth]),
          .din   (m_wdata[c*MacroWidth +: MacroWidth]),
          .dout  (dout[r][c*MacroWidth +: MacroWidth])
        );
      end
    end else begin : g_empty
      assign dout[r] = '0;
    end
  end

  // remember that a read was granted and which row it targeted
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_pend <= 1'b0;
      rd_row <= '0;
    end else begin
      rd_pend <= gnt & ~write_i;
      if (gnt && !write_i) rd_row <= row;
    end
  end

  assign rd_data = rd_pend ? dout[rd_row] : '0;

`ifdef PRIM_RAM_1P_OUTREG_EN
  logic rvalid_q;
  logic [Width-1:0] rdata_q;
  // extra pipeline stage on the read return path
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rvalid_q <= rd_pend;
      rdata_q <= rd_data;
    end
  end
  assign rvalid_o = rvalid_q;
  assign rdata_o = rdata_q;
`else
  assign rvalid_o = rd_pend;
  assign rdata_o = rd_data;
`endif
endmodule

// File: tb/tb_prim_freepdk45_ram_1p_tiled.sv
// tb_prim_freepdk45_ram_1p_tiled: directed table-driven bench for the tiled FreePDK45 RAM
module tb_prim_freepdk45_ram_1p_tiled;
  import prim_freepdk45_pkg::*;
`ifdef PRIM_RAM_1P_OUTREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam logic [63:0] ONES = '1;
  localparam int N = 18;

  typedef struct {
    logic        req;
    logic        wr;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic [63:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic wr = 1'b0;
  logic [11:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] wmask = '0;
  logic gnt, rvalid, busy;
  logic [63:0] rdata;
  ram_1p_cfg_t cfg = '0;
  int total = 0;
  int passed = 0;
  vec_t v [N];

  always #5 clk = ~clk;

  prim_freepdk45_ram_1p_tiled dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .gnt_o       (gnt),
    .write_i     (wr),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .wmask_i     (wmask),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .init_busy_o (busy),
    .cfg_i       (cfg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi + Lat; i++) begin
      if (i >= lo + Lat) begin
        automatic int k = i - Lat;
        automatic logic rd = v[k].req && !v[k].wr;
        chk($sformatf("rvalid[%0d]", k), {63'b0, rvalid}, {63'b0, rd});
        chk($sformatf("rdata[%0d]", k), rdata, rd ? v[k].exp : 64'h0);
      end
      if (i < hi) begin
        req = v[i].req; wr = v[i].wr; addr = v[i].addr; wdata = v[i].wdata; wmask = v[i].wmask;
      end else req = 1'b0;
      #1;
      if (i < hi) chk($sformatf("gnt[%0d]", i), {63'b0, gnt}, {63'b0, v[i].req});
      @(negedge clk);
    end
  endtask

  task automatic count_fill(input string name);
    automatic int n = 0;
    automatic logic gnt_seen = 1'b0;
    req = 1'b1; wr = 1'b0; addr = '0;
    while (busy && n < 5000) begin
      #1;
      gnt_seen |= gnt;
      n++;
      @(negedge clk);
    end
    chk({name, "_len"}, 64'(n), 64'd2048);
    chk({name, "_nognt"}, {63'b0, gnt_seen}, 64'd0);
  endtask

  initial begin
    v[0]  = '{1'b1, 1'b1, 12'h000, 64'hDEADBEEF_CAFEF00D, ONES, 64'h0};
    v[1]  = '{1'b1, 1'b1, 12'h800, 64'h01234567_89ABCDEF, ONES, 64'h0};
    v[2]  = '{1'b1, 1'b0, 12'h000, 64'h0, 64'h0, 64'hDEADBEEF_CAFEF00D};
    v[3]  = '{1'b1, 1'b0, 12'h800, 64'h0, 64'h0, 64'h01234567_89ABCDEF};
    v[4]  = '{1'b1, 1'b0, 12'h000, 64'h0, 64'h0, 64'hDEADBEEF_CAFEF00D};
    v[5]  = '{1'b1, 1'b1, 12'h005, ONES, ONES, 64'h0};
    v[6]  = '{1'b1, 1'b1, 12'h005, 64'h0, 64'h00000000_FFFF0000, 64'h0};
    v[7]  = '{1'b1, 1'b0, 12'h005, 64'h0, 64'h0, 64'hFFFFFFFF_0000FFFF};
    v[8]  = '{1'b1, 1'b0, 12'h800, 64'h0, 64'h0, 64'h01234567_89ABCDEF};
    v[9]  = '{1'b1, 1'b1, 12'h800, 64'h0, ONES, 64'h0};
    v[10] = '{1'b0, 1'b0, 12'h800, 64'h0, 64'h0, 64'h0};
    v[11] = '{1'b1, 1'b0, 12'h800, 64'h0, 64'h0, 64'h0};
    v[12] = '{1'b1, 1'b0, 12'h7FF, 64'h0, 64'h0, 64'h0};
    v[13] = '{1'b1, 1'b1, 12'h801, 64'h55555555_AAAAAAAA, 64'hFFFFFFFF_00000000, 64'h0};
    v[14] = '{1'b1, 1'b0, 12'h801, 64'h0, 64'h0, 64'h55555555_00000000};
    v[15] = '{1'b1, 1'b0, 12'h000, 64'h0, 64'h0, 64'h0};
    v[16] = '{1'b1, 1'b0, 12'h800, 64'h0, 64'h0, 64'h0};
    v[17] = '{1'b1, 1'b0, 12'h801, 64'h0, 64'h0, 64'h0};

    rst_n = 1'b0; req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd1);
    chk("rst_rvalid", {63'b0, rvalid}, 64'd0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_gnt", {63'b0, gnt}, 64'd0);
    rst_n = 1'b1;
    count_fill("fill1");
    #1;
    chk("fill1_gnt", {63'b0, gnt}, 64'd1);
    @(negedge clk);
    req = 1'b0;
    repeat (Lat - 1) @(negedge clk);
    chk("fill1_rvalid", {63'b0, rvalid}, 64'd1);
    chk("fill1_rdata", rdata, 64'h0);
    @(negedge clk);

    run(0, 15);

    req = 1'b1; wr = 1'b0; addr = 12'h000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("inflight_rvalid", {63'b0, rvalid}, 64'd0);
    chk("inflight_rdata", rdata, 64'h0);
    chk("inflight_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b1; req = 1'b0;
    repeat (1000) @(negedge clk);
    chk("mid_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_fill("fill2");
    req = 1'b0;
    @(negedge clk);
    run(15, 18);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
